// File: rtl/rom_arbiter_2p_pkg.sv
// Shared types and constants for the two-port ROM arbiter and burst sequencer.
package rom_arbiter_2p_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Cycles from request acceptance to the matching valid on the owning port.
  localparam int unsigned RD_LAT = 3;

  typedef struct packed {
    logic valid;
    logic owner;
    logic last;
  } token_t;

endpackage

// File: rtl/rom_arbiter_2p_rr_arb2.sv
// Stateless two-way round-robin select; a contended grant goes to the port not granted last.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  input  logic enable,
  output logic gnt0,
  output logic gnt1
);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (enable) begin
      if (req0 && req1) begin
        gnt0 = last_gnt;
        gnt1 = ~last_gnt;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

endmodule

// File: rtl/rom_arbiter_2p.sv
// Two-port round-robin ROM arbiter: accepts bursts, walks the ROM address and
// steers each returned word to the port that owns it.
module rom_arbiter_2p
  import rom_arbiter_2p_pkg::*;
#(
  parameter int unsigned BITS_DATA = 8,
  parameter int unsigned BITS_ADDR = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [BITS_ADDR-1:0] addr0,
  input  logic [BITS_ADDR-1:0] addr1,
  input  logic [BITS_ADDR-1:0] len0,
  input  logic [BITS_ADDR-1:0] len1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic [BITS_ADDR-1:0] rom_addr,
  input  logic [BITS_DATA-1:0] rom_data,
  output logic                 valid0,
  output logic                 valid1,
  output logic [BITS_DATA-1:0] data0,
  output logic [BITS_DATA-1:0] data1,
  output logic                 last0,
  output logic                 last1,
  output logic                 busy
);

  state_e                 state_q, state_d;
  logic [BITS_ADDR-1:0]   rom_addr_q, rom_addr_d;
  logic [BITS_ADDR-1:0]   remaining_q, remaining_d;
  logic                   owner_q, owner_d;
  logic                   last_gnt_q, last_gnt_d;
  token_t                 s1_q, s1_d;
  token_t                 s2_q, s2_d;
  logic                   valid0_q, valid0_d, valid1_q, valid1_d;
  logic                   last0_q, last0_d, last1_q, last1_d;
  logic [BITS_DATA-1:0]   data0_q, data0_d, data1_q, data1_d;
  logic                   busy_q, busy_d;

  logic                   accept;
  logic                   sel_port;
  logic [BITS_ADDR-1:0]   sel_addr;
  logic [BITS_ADDR-1:0]   sel_len;

  rr_arb2 u_arb (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt_q),
    .enable   (state_q == ST_IDLE),
    .gnt0     (gnt0),
    .gnt1     (gnt1)
  );

  assign accept   = gnt0 | gnt1;
  assign sel_port = gnt1;
  assign sel_addr = gnt1 ? addr1 : addr0;
  assign sel_len  = gnt1 ? len1 : len0;

  // Next-state, address counter and issue token.
  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    remaining_d = remaining_q;
    owner_d     = owner_q;
    last_gnt_d  = last_gnt_q;
    s1_d        = '0;
    if (state_q == ST_IDLE) begin
      if (accept) begin
        rom_addr_d  = sel_addr;
        remaining_d = sel_len;
        owner_d     = sel_port;
        last_gnt_d  = sel_port;
        s1_d        = '{valid: 1'b1, owner: sel_port, last: (sel_len == '0)};
        state_d     = (sel_len == '0) ? ST_IDLE : ST_BURST;
      end
    end else begin
      rom_addr_d  = rom_addr_q + BITS_ADDR'(1);
      remaining_d = remaining_q - BITS_ADDR'(1);
      s1_d        = '{valid: 1'b1, owner: owner_q, last: (remaining_q == BITS_ADDR'(1))};
      if (remaining_q == BITS_ADDR'(1)) begin
        state_d = ST_IDLE;
      end
    end
  end

  // Return pipeline: s2 lines up with rom_data, outputs one stage later.
  always_comb begin
    s2_d     = s1_q;
    valid0_d = s2_q.valid & ~s2_q.owner;
    valid1_d = s2_q.valid & s2_q.owner;
    last0_d  = valid0_d & s2_q.last;
    last1_d  = valid1_d & s2_q.last;
    data0_d  = valid0_d ? rom_data : data0_q;
    data1_d  = valid1_d ? rom_data : data1_q;
    busy_d   = (state_d == ST_BURST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rom_addr_q  <= '0;
      remaining_q <= '0;
      owner_q     <= 1'b0;
      last_gnt_q  <= 1'b1;
      s1_q        <= '0;
      s2_q        <= '0;
      valid0_q    <= 1'b0;
      valid1_q    <= 1'b0;
      last0_q     <= 1'b0;
      last1_q     <= 1'b0;
      data0_q     <= '0;
      data1_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      remaining_q <= remaining_d;
      owner_q     <= owner_d;
      last_gnt_q  <= last_gnt_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      valid0_q    <= valid0_d;
      valid1_q    <= valid1_d;
      last0_q     <= last0_d;
      last1_q     <= last1_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      busy_q      <= busy_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign valid0   = valid0_q;
  assign valid1   = valid1_q;
  assign last0    = last0_q;
  assign last1    = last1_q;
  assign data0    = data0_q;
  assign data1    = data1_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rom_arbiter_2p.sv
// Bench for rom_arbiter_2p: directed scenarios plus random traffic against a
// per-cycle expectation table built from the arbitration and latency rules.
module tb_rom_arbiter_2p;
  import rom_arbiter_2p_pkg::*;

  localparam int unsigned BD    = 8;
  localparam int unsigned BA    = 3;
  localparam int          DEPTH = 8;
  localparam int          NC    = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [BA-1:0] addr0 = '0, addr1 = '0, len0 = '0, len1 = '0;
  logic          gnt0, gnt1;
  logic [BA-1:0] rom_addr;
  logic [BD-1:0] rom_data;
  logic          valid0, valid1, last0, last1, busy;
  logic [BD-1:0] data0, data1;

  rom_arbiter_2p #(.BITS_DATA(BD), .BITS_ADDR(BA)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
    .gnt0(gnt0), .gnt1(gnt1), .rom_addr(rom_addr), .rom_data(rom_data),
    .valid0(valid0), .valid1(valid1), .data0(data0), .data1(data1),
    .last0(last0), .last1(last1), .busy(busy)
  );

  always #5 clk = ~clk;

  // External synchronous-read ROM.
  logic [BD-1:0] mem [DEPTH];
  always @(posedge clk) rom_data <= mem[rom_addr];

  // Reference model: expected outputs indexed by cycle number.
  int            cyc, free_cyc, nvec, nerr;
  bit            mlast, p0, p1, do_rst;
  logic [BA-1:0] a0, a1, l0, l1, ra;
  logic [BD-1:0] hold0, hold1;
  bit            ev0 [NC], ev1 [NC], el0 [NC], el1 [NC], eb [NC], eaf [NC];
  logic [BD-1:0] ed [NC];
  logic [BA-1:0] ea [NC];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic schedule(input bit port, input logic [BA-1:0] addr, input logic [BA-1:0] len);
    int n;
    int c;
    n = int'(len) + 1;
    for (int k = 0; k < n; k++) begin
      c      = cyc + 1 + k;
      eaf[c] = 1'b1;
      ea[c]  = BA'((int'(addr) + k) % DEPTH);
      c      = cyc + int'(RD_LAT) + k;
      ed[c]  = mem[(int'(addr) + k) % DEPTH];
      if (port) begin ev1[c] = 1'b1; el1[c] = (k == n - 1); end
      else      begin ev0[c] = 1'b1; el0[c] = (k == n - 1); end
    end
    for (int k = 1; k < n; k++) eb[cyc + k] = 1'b1;
    free_cyc = cyc + n;
    mlast    = port;
  endtask

  // One clock cycle: drive, check at negedge, advance the model.
  task automatic step();
    bit            idle, g0, g1;
    logic [BA-1:0] xa;
    logic [BD-1:0] xd0, xd1;
    req0 = p0; addr0 = a0; len0 = l0;
    req1 = p1; addr1 = a1; len1 = l1;
    rst  = do_rst;
    @(negedge clk);
    idle = (cyc >= free_cyc);
    g0   = idle && p0 && (!p1 || mlast);
    g1   = idle && p1 && (!p0 || !mlast);
    xa   = eaf[cyc] ? ea[cyc] : ra;
    xd0  = ev0[cyc] ? ed[cyc] : hold0;
    xd1  = ev1[cyc] ? ed[cyc] : hold1;
    chk("gnt0",     32'(gnt0),     32'(g0));
    chk("gnt1",     32'(gnt1),     32'(g1));
    chk("busy",     32'(busy),     32'(eb[cyc]));
    chk("valid0",   32'(valid0),   32'(ev0[cyc]));
    chk("valid1",   32'(valid1),   32'(ev1[cyc]));
    chk("last0",    32'(last0),    32'(el0[cyc]));
    chk("last1",    32'(last1),    32'(el1[cyc]));
    chk("data0",    32'(data0),    32'(xd0));
    chk("data1",    32'(data1),    32'(xd1));
    chk("rom_addr", 32'(rom_addr), 32'(xa));
    ra = xa; hold0 = xd0; hold1 = xd1;
    if (do_rst) begin
      for (int c = cyc + 1; c < NC; c++) begin
        ev0[c] = 1'b0; ev1[c] = 1'b0; el0[c] = 1'b0; el1[c] = 1'b0;
        eb[c]  = 1'b0; eaf[c] = 1'b0;
      end
      free_cyc = cyc + 1; mlast = 1'b1; ra = '0; hold0 = '0; hold1 = '0;
    end else if (g0) begin
      schedule(1'b0, a0, l0); p0 = 1'b0;
    end else if (g1) begin
      schedule(1'b1, a1, l1); p1 = 1'b0;
    end
    @(posedge clk); #1;
    cyc++;
    do_rst = 1'b0;
    if (cyc >= NC - 16) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NC - 16);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic wait_grant();
    int t;
    t = 0;
    while ((p0 || p1) && t < 64) begin step(); t++; end
    chk("grant_wait", 32'({p0, p1}), 32'(0));
    p0 = 1'b0; p1 = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) step();
  endtask

  initial begin
    nvec = 0; nerr = 0; cyc = 0; free_cyc = 0; mlast = 1'b1;
    p0 = 0; p1 = 0; do_rst = 0; a0 = '0; a1 = '0; l0 = '0; l1 = '0;
    ra = '0; hold0 = '0; hold1 = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = BD'(8'h10 + i);
    repeat (3) @(posedge clk);
    #1;

    drain(2);                                           // reset state
    a0 = 3; l0 = 0; p0 = 1; wait_grant(); drain(5);     // single read
    a1 = 6; l1 = 3; p1 = 1; wait_grant(); drain(8);     // burst with wrap
    a0 = 1; a1 = 2; l0 = 0; l1 = 0; p0 = 1; p1 = 1; wait_grant();
    a0 = 4; a1 = 5; p0 = 1; p1 = 1; wait_grant(); drain(5);  // contention twice
    a0 = 0; l0 = 2; p0 = 1; step();                     // request during burst
    a1 = 5; l1 = 0; p1 = 1; wait_grant(); drain(8);
    a0 = 2; l0 = 7; p0 = 1; step(); step();             // reset mid-burst in C2
    do_rst = 1; step(); drain(6);
    a0 = 3; l0 = 0; p0 = 1; wait_grant(); drain(5);
    for (int i = 0; i < 8; i++) begin                   // throughput
      a0 = BA'(i); l0 = 0; p0 = 1; wait_grant();
    end
    drain(6);

    for (int i = 0; i < DEPTH; i++) mem[i] = BD'($urandom);
    for (int i = 0; i < 400; i++) begin
      if (!p0 && ($urandom % 3 == 0)) begin
        a0 = BA'($urandom); l0 = ($urandom % 4 == 0) ? BA'($urandom) : BA'($urandom % 2); p0 = 1;
      end
      if (!p1 && ($urandom % 3 == 0)) begin
        a1 = BA'($urandom); l1 = ($urandom % 4 == 0) ? BA'($urandom) : BA'($urandom % 2); p1 = 1;
      end
      if ($urandom % 97 == 0) do_rst = 1;
      step();
    end
    wait_grant();
    drain(12);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
